mem_arbiter: RTL

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (IF)
// and the data stage (ME), with a per-access ack timeout.
module mem_arbiter #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [ADDR_W-1:0]   if_addr_i,
  output logic [DATA_W-1:0]   if_rdata_o,
  output logic                if_done_o,
  input  logic                me_req_i,
  input  logic                me_we_i,
  input  logic [ADDR_W-1:0]   me_addr_i,
  input  logic [DATA_W-1:0]   me_wdata_i,
  input  logic [DATA_W/8-1:0] me_sel_i,
  output logic [DATA_W-1:0]   me_rdata_o,
  output logic                me_done_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [ADDR_W-1:0]   mem_addr_o,
  output logic [DATA_W-1:0]   mem_wdata_o,
  output logic [DATA_W/8-1:0] mem_sel_o,
  input  logic [DATA_W-1:0]   mem_rdata_i,
  input  logic                mem_ack_i,
  output logic                err_o,
  output logic                stall_o,
  output logic [1:0]          dbg_state_o
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SERVE_IF = 2'd1,
    SERVE_ME = 2'd2,
    DONE     = 2'd3
  } state_e;

  state_e              state_q;
  logic                last_me_q;
  logic [7:0]          wait_q;
  logic                mem_req_q, mem_we_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q;
  logic [DATA_W/8-1:0] mem_sel_q;
  logic [DATA_W-1:0]   if_rdata_q, me_rdata_q;
  logic                if_done_q, me_done_q, err_q;

  logic                if_elig_d, me_elig_d, grant_if_d, grant_me_d;
  logic [7:0]          wait_d;
  logic                timeout_d;

  // Handshake: a requester holds req high until it sees its one-cycle done
  // pulse; rdata is valid in that same cycle. During DONE only the requester
  // that did not just finish may be granted.
  always_comb begin
    if_elig_d  = if_req_i & ((state_q == IDLE) | ((state_q == DONE) &  last_me_q));
    me_elig_d  = me_req_i & ((state_q == IDLE) | ((state_q == DONE) & ~last_me_q));
    grant_me_d = me_elig_d & (~if_elig_d | ~last_me_q);
    grant_if_d = if_elig_d & ~grant_me_d;
    wait_d     = wait_q + 8'd1;
    timeout_d  = (wait_d == 8'(TIMEOUT));
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      last_me_q   <= 1'b0;
      wait_q      <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_sel_q   <= '0;
      if_rdata_q  <= '0;
      me_rdata_q  <= '0;
      if_done_q   <= 1'b0;
      me_done_q   <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      me_done_q <= 1'b0;
      err_q     <= 1'b0;
      case (state_q)
        IDLE, DONE: begin
          if (grant_me_d) begin
            state_q     <= SERVE_ME;
            last_me_q   <= 1'b1;
            wait_q      <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= me_we_i;
            mem_addr_q  <= me_addr_i;
            mem_wdata_q <= me_wdata_i;
            mem_sel_q   <= me_sel_i;
          end else if (grant_if_d) begin
            state_q     <= SERVE_IF;
            last_me_q   <= 1'b0;
            wait_q      <= '0;
            mem_req_q   <= 1'b1;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= if_addr_i;
            mem_wdata_q <= '0;
            mem_sel_q   <= '1;
          end else begin
            state_q <= IDLE;
          end
        end
        SERVE_IF, SERVE_ME: begin
          // Ack takes priority over a timeout landing on the same edge.
          if (mem_ack_i) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            if (state_q == SERVE_IF) begin
              if_rdata_q <= mem_rdata_i;
              if_done_q  <= 1'b1;
            end else begin
              me_rdata_q <= mem_rdata_i;
              me_done_q  <= 1'b1;
            end
          end else begin
            wait_q <= wait_d;
            if (timeout_d) begin
              state_q   <= DONE;
              mem_req_q <= 1'b0;
              err_q     <= 1'b1;
              if (state_q == SERVE_IF) begin
                if_rdata_q <= '0;
                if_done_q  <= 1'b1;
              end else begin
                me_rdata_q <= '0;
                me_done_q  <= 1'b1;
              end
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign if_rdata_o  = if_rdata_q;
  assign if_done_o   = if_done_q;
  assign me_rdata_o  = me_rdata_q;
  assign me_done_o   = me_done_q;
  assign mem_req_o   = mem_req_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;
  assign mem_sel_o   = mem_sel_q;
  assign err_o       = err_q;
  assign dbg_state_o = state_q;
  assign stall_o     = (if_req_i & ~if_done_q) | (me_req_i & ~me_done_q);

endmodule
